// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and request bundle for the wait-state data memory.
// Also hosts the alignment rule so every memory variant flags the same accesses.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Widest byte address a request can carry; narrower buses are zero-extended.
    localparam int REQ_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic                  unsigned_ld;
        logic [REQ_ADDR_W-1:0] address;
        logic [31:0]           write_data;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for little-endian 32-bit memories: store enables/replicated
// data on the way in, right-justify plus sign/zero extension on the way out.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = 32'h0;
        load_data   = 32'h0;
        sel_byte    = 8'(load_word >> {byte_off, 3'b000});
        sel_half    = byte_off[1] ? load_word[31:16] : load_word[15:0];
        case (size)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << byte_off;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{~unsigned_ld & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                byte_en     = byte_off[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{~unsigned_ld & sel_half[15]}}, sel_half};
            end
            SZ_WORD: begin
                byte_en     = 4'b1111;
                store_lanes = store_data;
                load_data   = load_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_wait.sv
// Byte-addressed data memory behind a req/ready handshake with LATENCY wait cycles.
// Stores and load results commit on the edge that enters DONE.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  write,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic                  busy,
    output logic                  ready,
    output logic [31:0]           readData,
    output logic                  misaligned,
    output logic                  out_of_range
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    dmem_req_t        req_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic [31:0]      read_data_reg;
    logic             misaligned_reg;
    logic             out_of_range_reg;

    dmem_req_t        new_req;
    dmem_req_t        commit_req;
    logic             commit_en;
    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic             addr_misaligned;
    logic             addr_out_of_range;
    logic             access_err;
    logic [3:0]       byte_en;
    logic [3:0]       lane_we;
    logic [31:0]      store_lanes;
    logic [31:0]      load_word;
    logic [31:0]      load_data;

    always_comb begin
        new_req                        = '0;
        new_req.write                  = write;
        new_req.size                   = size;
        new_req.unsigned_ld            = unsigned_ld;
        new_req.address[ADDR_WIDTH-1:0] = address;
        new_req.write_data             = writeData;
    end

    assign accept = req && (state_reg != WAIT);

    // With no wait cycles the access commits on its own accept edge, straight from the inputs.
    generate
        if (LATENCY == 0) begin : g_direct
            assign commit_req = new_req;
            assign commit_en  = accept;
        end else begin : g_waited
            assign commit_req = req_reg;
            assign commit_en  = (state_reg == WAIT) && (cnt_reg == '0);
        end
    endgenerate

    assign word_idx          = commit_req.address[IDX_W+1:2];
    assign addr_out_of_range = |(commit_req.address >> (IDX_W + 2));
    assign addr_misaligned   = is_misaligned(commit_req.size, commit_req.address[1:0]);
    assign access_err        = addr_out_of_range | addr_misaligned;

    dmem_lane_align u_align (
        .size        (commit_req.size),
        .unsigned_ld (commit_req.unsigned_ld),
        .byte_off    (commit_req.address[1:0]),
        .store_data  (commit_req.write_data),
        .load_word   (load_word),
        .byte_en     (byte_en),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    // One array per byte lane keeps each write port single-driver with a plain enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS];

            assign lane_we[gi] = reset_n & commit_en & commit_req.write & ~access_err & byte_en[gi];

            always_ff @(posedge clock) begin
                if (lane_we[gi]) begin
                    mem_lane[word_idx] <= store_lanes[8*gi +: 8];
                end
            end

            assign load_word[8*gi +: 8] = mem_lane[word_idx];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            req_reg          <= '0;
            busy_reg         <= 1'b0;
            ready_reg        <= 1'b0;
            read_data_reg    <= 32'h0;
            misaligned_reg   <= 1'b0;
            out_of_range_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (req) begin
                        req_reg <= new_req;
                        if (LATENCY == 0) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_LOAD;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Good stores leave readData as it was; any flagged access forces it to zero.
            if (commit_en) begin
                misaligned_reg   <= addr_misaligned;
                out_of_range_reg <= addr_out_of_range;
                if (access_err) begin
                    read_data_reg <= 32'h0;
                end else if (!commit_req.write) begin
                    read_data_reg <= load_data;
                end
            end
        end
    end

    assign busy         = busy_reg;
    assign ready        = ready_reg;
    assign readData     = read_data_reg;
    assign misaligned   = misaligned_reg;
    assign out_of_range = out_of_range_reg;

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: directed table, abort and back-to-back sequences, then
// random traffic checked against a byte-array model of the memory.
module tb_dmem_wait;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int AW    = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0;
    logic          write = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          unsigned_ld = 1'b0;
    logic [AW-1:0] address = '0;
    logic [31:0]   writeData = 32'h0;
    logic          busy, ready, misaligned, out_of_range;
    logic [31:0]   readData;

    int total = 0;
    int bad   = 0;

    logic [7:0]  model_mem [4*DEPTH];
    logic [31:0] held_rd = 32'h0;

    always #5 clock = ~clock;

    dmem_wait #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .write        (write),
        .size         (size),
        .unsigned_ld  (unsigned_ld),
        .address      (address),
        .writeData    (writeData),
        .busy         (busy),
        .ready        (ready),
        .readData     (readData),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        mis;
        logic        oor;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input logic mis, input logic oor);
        vec_t v;
        v.w = w; v.sz = sz; v.u = u; v.a = a; v.d = d; v.rd = rd; v.mis = mis; v.oor = oor;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, results built with plain arithmetic.
    task automatic model_apply(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] e_rd, output logic e_mis, output logic e_oor);
        int nbytes;
        logic [31:0] v;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e_oor  = a >= 32'(4 * DEPTH);
        e_mis  = (sz == 2'd3) || ((a % nbytes) != 0);
        if (e_mis || e_oor) begin
            e_rd = 32'h0;
        end else if (w) begin
            for (int i = 0; i < nbytes; i++) model_mem[a + i] = d[8*i +: 8];
            e_rd = held_rd;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
            if (!u && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
            e_rd = v;
        end
        held_rd = e_rd;
    endtask

    task automatic run_and_check(input string name, input logic w, input logic [1:0] sz,
                                 input logic u, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] e_rd, input logic e_mis, input logic e_oor);
        int lat;
        logic [31:0] rd;
        logic mis, oor;
        write = w; size = sz; unsigned_ld = u; address = a; writeData = d; req = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        write = ~w; address = a ^ 32'h4; size = SZ_BYTE; unsigned_ld = ~u; writeData = ~d;
        check({name, "_busy"}, 32'(busy), 32'd1);
        lat = -1;
        rd = 32'h0; mis = 1'b0; oor = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (ready) begin
                lat = k + 1;
                rd = readData; mis = misaligned; oor = out_of_range;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(LAT + 1));
        check({name, "_rd"}, rd, e_rd);
        check({name, "_mis"}, 32'(mis), 32'(e_mis));
        check({name, "_oor"}, 32'(oor), 32'(e_oor));
        @(posedge clock); #1;
        check({name, "_pulse"}, 32'(ready), 32'd0);
        $display("%s: w=%0d sz=%0d u=%0d a=%h d=%h -> rd=%h mis=%0d oor=%0d lat=%0d",
                 name, w, sz, u, a, d, rd, mis, oor, lat);
    endtask

    task automatic rand_txn(input string name, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e_rd;
        logic e_mis, e_oor;
        model_apply(w, sz, u, a, d, e_rd, e_mis, e_oor);
        run_and_check(name, w, sz, u, a, d, e_rd, e_mis, e_oor);
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] good_addr [3];
        logic [31:0] good_data [3];
        int          rdy_cyc[$];
        logic [31:0] rdy_dat[$];
        logic        rdy_err[$];
        logic        seen;
        logic [1:0]  rsz;
        logic [31:0] ra;
        int          r;

        // Hand-derived vectors; stores expect the readData left by the previous load.
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h010, 32'hDEADBEEF, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h010, 32'h00000000, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, SZ_BYTE, 0, 32'h013, 32'h00000080, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, SZ_BYTE, 0, 32'h013, 32'h0,        32'hFFFFFF80, 0, 0));
        tbl.push_back(mk(0, SZ_BYTE, 1, 32'h013, 32'h0,        32'h00000080, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h010, 32'h0,        32'h80000000, 0, 0));
        tbl.push_back(mk(1, SZ_HALF, 0, 32'h012, 32'h00001234, 32'h80000000, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h010, 32'h0,        32'h12340000, 0, 0));
        tbl.push_back(mk(0, SZ_HALF, 0, 32'h012, 32'h0,        32'h00001234, 0, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h000, 32'h11223344, 32'h00001234, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h002, 32'h0,        32'h00000000, 1, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h001, 32'hCAFEF00D, 32'h00000000, 1, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h000, 32'h0,        32'h11223344, 0, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h400, 32'hCAFEF00D, 32'h00000000, 0, 1));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h000, 32'h0,        32'h11223344, 0, 0));
        tbl.push_back(mk(1, SZ_BYTE, 0, 32'h401, 32'h000000FF, 32'h00000000, 0, 1));
        tbl.push_back(mk(0, SZ_HALF, 0, 32'h011, 32'h0,        32'h00000000, 1, 0));
        tbl.push_back(mk(0, 2'b11,   0, 32'h010, 32'h0,        32'h00000000, 1, 0));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h3FC, 32'h8000ABCD, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, SZ_HALF, 0, 32'h3FE, 32'h0,        32'hFFFF8000, 0, 0));
        tbl.push_back(mk(0, SZ_HALF, 1, 32'h3FC, 32'h0,        32'h0000ABCD, 0, 0));
        tbl.push_back(mk(0, SZ_BYTE, 0, 32'h3FD, 32'h0,        32'hFFFFFFAB, 0, 0));
        tbl.push_back(mk(0, SZ_WORD, 0, 32'h402, 32'h0,        32'h00000000, 1, 1));
        tbl.push_back(mk(1, SZ_WORD, 0, 32'h020, 32'hA5A5A5A5, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, SZ_BYTE, 0, 32'h3FD, 32'h0,        32'hFFFFFFAB, 0, 0));

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rd", readData, 32'h0);
        check("reset_mis", 32'(misaligned), 32'd0);
        check("reset_oor", 32'(out_of_range), 32'd0);

        foreach (tbl[i]) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u,
                          tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].mis, tbl[i].oor);
        end

        // Abort: reset lands on the first WAIT edge of a store to 0x20.
        write = 1'b1; size = SZ_WORD; unsigned_ld = 1'b0; address = 32'h20;
        writeData = 32'h12345678; req = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("abort_busy_clr", 32'(busy), 32'd0);
        check("abort_rd_clr", readData, 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (ready) seen = 1'b1;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        run_and_check("abort_reload", 0, SZ_WORD, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, 0);

        // Back-to-back: req held 9 cycles, only cycles 0/3/6 carry a good load.
        good_addr[0] = 32'h000; good_data[0] = 32'h11223344;
        good_addr[1] = 32'h010; good_data[1] = 32'h12340000;
        good_addr[2] = 32'h020; good_data[2] = 32'hA5A5A5A5;
        for (int c = 0; c < 12; c++) begin
            if (c < 9) begin
                req = 1'b1;
                if (c % 3 == 0) begin
                    write = 1'b0; size = SZ_WORD; unsigned_ld = 1'b0; address = good_addr[c/3];
                end else begin
                    write = 1'b1; size = SZ_BYTE; address = 32'h400 + 32'(c);
                    writeData = $urandom;
                end
            end else begin
                req = 1'b0;
            end
            @(posedge clock); #1;
            if (ready) begin
                rdy_cyc.push_back(c + 1);
                rdy_dat.push_back(readData);
                rdy_err.push_back(misaligned | out_of_range);
            end
        end
        req = 1'b0;
        check("b2b_count", 32'(rdy_cyc.size()), 32'd3);
        for (int i = 0; i < 3 && i < rdy_cyc.size(); i++) begin
            check($sformatf("b2b_cycle%0d", i), 32'(rdy_cyc[i]), 32'(3 * (i + 1)));
            check($sformatf("b2b_rd%0d", i), rdy_dat[i], good_data[i]);
            check($sformatf("b2b_err%0d", i), 32'(rdy_err[i]), 32'd0);
            $display("b2b%0d: ready cycle=%0d rd=%h", i, rdy_cyc[i], rdy_dat[i]);
        end
        check("b2b_idle", 32'(busy), 32'd0);
        held_rd = 32'hA5A5A5A5;

        // Random traffic over the first 16 words, with some out-of-range addresses.
        for (int w = 0; w < 16; w++) begin
            rand_txn($sformatf("fill%0d", w), 1, SZ_WORD, 0, 32'(4 * w), $urandom);
        end
        for (int n = 0; n < 60; n++) begin
            r   = $urandom_range(0, 9);
            rsz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : 2'b11;
            ra  = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                              : 32'($urandom_range(0, 63));
            rand_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rsz,
                     1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
